// File: rtl/demux_sched_pkg.sv
// Shared definitions for the 1:4 round-robin burst dispatcher.
//   state_e  : dispatcher FSM states (IDLE, ARB, XFER)
//   NUM_CH   : number of output channels
//   rr_pick  : round-robin search over a 4-bit enable mask, starting after ptr;
//              returns {found, idx[1:0]}
package demux_sched_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_e;

  // Search order is ptr+1, ptr+2, ptr+3, ptr+4 (mod 4). Walking the offsets
  // from farthest to nearest lets the nearest enabled channel overwrite the
  // result last, so it wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin pick among four channels.
// Ports:
//   i_mask  : channel enable mask (bit k enables channel k)
//   i_ptr   : last channel served; search starts at i_ptr+1
//   o_found : 1 when at least one channel is enabled
//   o_idx   : chosen channel (valid when o_found)
module rr_arbiter4
  import demux_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [1:0]        i_ptr,
  output logic              o_found,
  output logic [1:0]        o_idx
);

  assign {o_found, o_idx} = rr_pick(i_mask, i_ptr);

endmodule

// File: rtl/demux_rr_dispatcher.sv
// Scheduler for a 1:4 demux datapath. A single valid/ready burst stream is
// steered, one whole burst at a time, to one of four output channels chosen
// round-robin among the enabled channels. One arbitration bubble separates
// bursts; bursts longer than MAX_BURST beats are cut and the remainder is
// dispatched as a new burst.
//
// Optional feature macro: DEMUX_SCHED_STATS_EN adds per-channel beat counters
// (stats_clr, stat_beats). Without it those ports and counters do not exist.
//
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   ch_en       : channel enable mask
//   in_valid / in_ready / in_data / in_last : input burst stream
//   out_valid   : one-hot per-channel valid, zero outside XFER
//   out_ready   : per-channel ready
//   out_data    : payload broadcast to all channels
//   out_last    : in_last, or forced high on the MAX_BURST-th beat
//   sel         : registered demux select
//   busy        : high while a burst is being transferred
//   trunc_err   : one-cycle pulse after a burst is cut at MAX_BURST
//   stats_clr   : (stats build) synchronous clear of the beat counters
//   stat_beats  : (stats build) {ch3, ch2, ch1, ch0} beat counters, CNT_W each
module demux_rr_dispatcher
  import demux_sched_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        sel,
  output logic              busy,
  output logic              trunc_err
`ifdef DEMUX_SCHED_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [NUM_CH*CNT_W-1:0] stat_beats
`endif
);

  localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  if (MAX_BURST < 2 || CNT_W < 1) begin : g_param_check
    $error("demux_rr_dispatcher: MAX_BURST must be >= 2 and CNT_W >= 1");
  end

  state_e          r_state;
  state_e          w_state_nxt;
  logic [1:0]      r_sel;
  logic [1:0]      r_rr_ptr;
  logic [BC_W-1:0] r_beat_cnt;
  logic            r_trunc_err;

  logic            w_arb_found;
  logic [1:0]      w_arb_idx;
  logic            w_xfer;
  logic            w_hs;
  logic            w_at_max;
  logic            w_final;

  rr_arbiter4 u_arb (
    .i_mask  (ch_en),
    .i_ptr   (r_rr_ptr),
    .o_found (w_arb_found),
    .o_idx   (w_arb_idx)
  );

  // Steering: zero-latency pass-through to the selected channel in XFER only.
  assign w_xfer   = (r_state == XFER);
  assign in_ready = w_xfer & out_ready[r_sel];
  assign w_hs     = in_valid & in_ready;
  assign w_at_max = (r_beat_cnt == BC_W'(MAX_BURST - 1));
  assign w_final  = w_hs & (in_last | w_at_max);

  always_comb begin
    out_valid = '0;
    if (w_xfer) out_valid[r_sel] = in_valid;
  end

  assign out_data  = in_data;
  assign out_last  = in_last | (w_xfer & w_at_max);
  assign sel       = r_sel;
  assign busy      = w_xfer;
  assign trunc_err = r_trunc_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (ch_en != '0) w_state_nxt = ARB;
      ARB:     w_state_nxt = w_arb_found ? XFER : IDLE;
      XFER:    if (w_final) w_state_nxt = ARB;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Select and pointer are loaded together in ARB, so the burst stays locked
  // to its channel even if ch_en changes while it is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= 2'd0;
      r_rr_ptr    <= 2'd3;
      r_beat_cnt  <= '0;
      r_trunc_err <= 1'b0;
    end else begin
      if (r_state == ARB && w_arb_found) begin
        r_sel    <= w_arb_idx;
        r_rr_ptr <= w_arb_idx;
      end
      if (w_hs) r_beat_cnt <= w_final ? '0 : r_beat_cnt + 1'b1;
      // A burst whose natural last beat coincides with the limit is not a cut.
      r_trunc_err <= w_hs & w_at_max & ~in_last;
    end
  end

`ifdef DEMUX_SCHED_STATS_EN
  logic [CNT_W-1:0] r_stat [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) r_stat[k] <= '0;
    end else if (stats_clr) begin
      for (int k = 0; k < NUM_CH; k++) r_stat[k] <= '0;
    end else if (w_hs) begin
      r_stat[r_sel] <= r_stat[r_sel] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_stat_pack
    assign stat_beats[g*CNT_W +: CNT_W] = r_stat[g];
  end
`endif

endmodule
